// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: byte FIFOs between an external producer/consumer and the CPU input_port/OUT pins
module cpu_io_bridge #(
  parameter int DEPTH  = 4,
  parameter bit IRQ_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ext_in_data,
  input  logic       ext_in_valid,
  output logic       ext_in_ready,
  output logic [7:0] input_port,
  output logic       in_avail,
  input  logic       cpu_in_rd,
  output logic       interrupt,
  input  logic [7:0] OUT,
  input  logic       cpu_out_we,
  output logic [7:0] ext_out_data,
  output logic       ext_out_valid,
  input  logic       ext_out_ready,
  output logic       out_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    in_mem  [DEPTH];
  logic [7:0]    out_mem [DEPTH];
  logic [AW-1:0] in_wr, in_rd, out_wr, out_rd;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          announced, in_push, in_pop, out_push, out_pop, out_full;
  always_comb begin
    ext_in_ready  = in_cnt != CW'(DEPTH);
    in_avail      = in_cnt != '0;
    input_port    = in_avail ? in_mem[in_rd] : 8'h00;
    in_push       = ext_in_valid && ext_in_ready;
    in_pop        = cpu_in_rd && in_avail;
    out_full      = out_cnt == CW'(DEPTH);
    ext_out_valid = out_cnt != '0;
    ext_out_data  = ext_out_valid ? out_mem[out_rd] : 8'h00;
    out_push      = cpu_out_we && !out_full;
    out_pop       = ext_out_valid && ext_out_ready;
  end
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= ext_in_data;
    if (out_push) out_mem[out_wr] <= OUT;
  end
  // a pop on the announce edge suppresses the pulse; the new head is announced next edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr        <= '0;
      in_rd        <= '0;
      in_cnt       <= '0;
      out_wr       <= '0;
      out_rd       <= '0;
      out_cnt      <= '0;
      out_overflow <= 1'b0;
      interrupt    <= 1'b0;
      announced    <= 1'b0;
    end else begin
      if (in_push) in_wr <= in_wr + AW'(1);
      if (in_pop) in_rd <= in_rd + AW'(1);
      in_cnt <= in_cnt + CW'(in_push) - CW'(in_pop);
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop) out_rd <= out_rd + AW'(1);
      out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
      if (cpu_out_we && out_full) out_overflow <= 1'b1;
      interrupt <= IRQ_EN && in_avail && !announced && !in_pop;
      announced <= in_pop ? 1'b0 : (announced || (IRQ_EN && in_avail));
    end
  end
endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge: scoreboard bench for cpu_io_bridge (DEPTH=4, IRQ_EN=1)
module tb_cpu_io_bridge;
  localparam int DEPTH = 4;
  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] ext_in_data = '0, OUT = '0;
  logic       ext_in_valid = 1'b0, cpu_in_rd = 1'b0, cpu_out_we = 1'b0, ext_out_ready = 1'b0;
  logic       ext_in_ready, in_avail, interrupt, ext_out_valid, out_overflow;
  logic [7:0] input_port, ext_out_data;
  int         checks = 0, failures = 0;
  logic [7:0] in_q[$], out_q[$];
  logic       m_ann = 1'b0, m_irq = 1'b0, m_ovf = 1'b0;

  cpu_io_bridge #(.DEPTH(DEPTH), .IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .input_port(input_port), .in_avail(in_avail), .cpu_in_rd(cpu_in_rd), .interrupt(interrupt),
    .OUT(OUT), .cpu_out_we(cpu_out_we),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // drives one cycle of inputs and advances the reference queues across the edge
  task automatic cyc(input logic iv, input logic [7:0] id, input logic rd, input logic we,
                     input logic [7:0] od, input logic ordy);
    logic ipush, ipop, opush, opop, irq_n, ann_n;
    ext_in_valid = iv; ext_in_data = id; cpu_in_rd = rd;
    cpu_out_we = we; OUT = od; ext_out_ready = ordy;
    ipush = iv && (in_q.size() < DEPTH);
    ipop  = rd && (in_q.size() > 0);
    opush = we && (out_q.size() < DEPTH);
    opop  = ordy && (out_q.size() > 0);
    irq_n = (in_q.size() > 0) && !m_ann && !ipop;
    ann_n = ipop ? 1'b0 : (m_ann || (in_q.size() > 0));
    @(posedge clk); #1;
    m_irq = irq_n; m_ann = ann_n;
    if (we && !opush) m_ovf = 1'b1;
    if (ipop) void'(in_q.pop_front());
    if (ipush) in_q.push_back(id);
    if (opop) void'(out_q.pop_front());
    if (opush) out_q.push_back(od);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ext_in_ready); end
    checks++; if (in_avail !== 1'b0) begin failures++; $display("FAIL rst_avail got=%b exp=0", in_avail); end
    checks++; if (input_port !== 8'h00) begin failures++; $display("FAIL rst_port got=%h exp=00", input_port); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", interrupt); end
    checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("FAIL rst_ovalid got=%b exp=0", ext_out_valid); end
    checks++; if (ext_out_data !== 8'h00) begin failures++; $display("FAIL rst_odata got=%h exp=00", ext_out_data); end
    checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", out_overflow); end
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_single();
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (input_port !== 8'hA5) begin failures++; $display("FAIL single_port got=%h exp=a5", input_port); end
    checks++; if (in_avail !== 1'b1) begin failures++; $display("FAIL single_avail got=%b exp=1", in_avail); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_irq_early got=%b exp=0", interrupt); end
    idle();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL single_irq_pulse got=%b exp=1", interrupt); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_irq_repulse cyc=%0d got=%b exp=0", i, interrupt); end
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (in_avail !== 1'b0 || input_port !== 8'h00) begin failures++; $display("FAIL single_pop got=%b/%h exp=0/00", in_avail, input_port); end
  endtask

  task automatic test_full();
    logic [7:0] exp_seq[$];
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ext_in_ready); end
    repeat (2) cyc(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (input_port !== 8'h11 || ext_in_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%h/%b exp=11/0", input_port, ext_in_ready); end
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (input_port !== 8'h22) begin failures++; $display("FAIL full_pop_head got=%h exp=22", input_port); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL full_pop_irq got=%b exp=0", interrupt); end
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL full_fresh_irq got=%b exp=1", interrupt); end
    checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("FAIL full_refill got=%b exp=0", ext_in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (input_port !== exp_seq[i] || input_port !== in_q[0]) begin failures++; $display("FAIL full_drain idx=%0d got=%h exp=%h", i, input_port, exp_seq[i]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      checks++; if (interrupt !== m_irq) begin failures++; $display("FAIL full_drain_irq idx=%0d got=%b exp=%b", i, interrupt, m_irq); end
    end
    checks++; if (in_avail !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", in_avail); end
  endtask

  task automatic test_wrap();
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (in_avail !== 1'b0 || ext_in_ready !== 1'b1 || input_port !== 8'h00) begin failures++; $display("FAIL wrap_empty_pop got=%b/%b/%h exp=0/1/00", in_avail, ext_in_ready, input_port); end
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (input_port !== 8'(i) || input_port !== in_q[0]) begin failures++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, input_port, 8'(i)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      checks++; if (in_avail !== 1'b0 || interrupt !== 1'b0) begin failures++; $display("FAIL wrap_pop idx=%0d got=%b/%b exp=0/0", i, in_avail, interrupt); end
      if (i == 5) cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (in_avail !== 1'b0 || ext_in_ready !== 1'b1) begin failures++; $display("FAIL wrap_underflow got=%b/%b exp=0/1", in_avail, ext_in_ready); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      if (i == 3) begin
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", out_overflow); end
      end
    end
    checks++; if (out_overflow !== 1'b1 || out_overflow !== m_ovf) begin failures++; $display("FAIL ovf_set got=%b exp=1", out_overflow); end
    checks++; if (ext_out_valid !== 1'b1 || ext_out_data !== 8'h50) begin failures++; $display("FAIL ovf_head got=%b/%h exp=1/50", ext_out_valid, ext_out_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ext_out_data !== 8'(8'h50 + i) || ext_out_data !== out_q[0]) begin failures++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, ext_out_data, 8'(8'h50 + i)); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 8'h00) begin failures++; $display("FAIL ovf_empty got=%b/%h exp=0/00", ext_out_valid, ext_out_data); end
    checks++; if (out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", out_overflow); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b1, 8'hB2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (input_port !== in_q[0] || ext_out_data !== out_q[0]) begin failures++; $display("FAIL b2b_heads idx=%0d got=%h/%h exp=%h/%h", i, input_port, ext_out_data, in_q[0], out_q[0]); end
      cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1, 8'(8'hD0 + i), 1'b1);
      checks++; if (interrupt !== m_irq) begin failures++; $display("FAIL b2b_irq idx=%0d got=%b exp=%b", i, interrupt, m_irq); end
    end
    checks++; if (input_port !== 8'hC2 || ext_out_data !== 8'hD2) begin failures++; $display("FAIL b2b_order got=%h/%h exp=c2/d2", input_port, ext_out_data); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (input_port !== 8'hC3 || ext_out_data !== 8'hD3) begin failures++; $display("FAIL b2b_second got=%h/%h exp=c3/d3", input_port, ext_out_data); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (in_avail !== 1'b0 || ext_out_valid !== 1'b0) begin failures++; $display("FAIL b2b_count got=%b/%b exp=0/0", in_avail, ext_out_valid); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'hE1, 1'b0, 1'b1, 8'hF1, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hE3, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    in_q.delete(); out_q.delete(); m_ann = 1'b0; m_irq = 1'b0; m_ovf = 1'b0;
    checks++; if (in_avail !== 1'b0 || input_port !== 8'h00 || ext_in_ready !== 1'b1) begin failures++; $display("FAIL mid_in got=%b/%h/%b exp=0/00/1", in_avail, input_port, ext_in_ready); end
    checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 8'h00 || out_overflow !== 1'b0 || interrupt !== 1'b0) begin failures++; $display("FAIL mid_out got=%b/%h/%b/%b exp=0/00/0/0", ext_out_valid, ext_out_data, out_overflow, interrupt); end
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (interrupt !== 1'b0 || in_avail !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b/%b exp=0/0", i, interrupt, in_avail); end
    end
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (input_port !== 8'h77 || in_avail !== 1'b1) begin failures++; $display("FAIL mid_push got=%h/%b exp=77/1", input_port, in_avail); end
    idle();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL mid_irq got=%b exp=1", interrupt); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Byte-wide I/O bridge on the far side of the CPU's `input_port`, `OUT` and `interrupt` pins. An external producer pushes bytes through a valid/ready handshake into an input FIFO. The FIFO head is presented on `input_port`, and the bridge raises a one-cycle `interrupt` per new head byte. Bytes the CPU writes to `OUT`, qualified by a write strobe from the decoder, are queued in an output FIFO and drained to an external consumer over a second valid/ready handshake.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2; identical for both FIFOs.
- `IRQ_EN`, 1: 1 enables `interrupt` generation; 0 ties `interrupt` low.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `ext_in_data`  in  8  byte from external producer.
- `ext_in_valid`  in  1  producer has a byte.
- `ext_in_ready`  out  1  input FIFO not full.
- `input_port`  out  8  input FIFO head; 8'h00 when empty.
- `in_avail`  out  1  input FIFO non-empty.
- `cpu_in_rd`  in  1  one-cycle pop of input head (IN instruction retired).
- `interrupt`  out  1  one-cycle pulse announcing a new head byte.
- `OUT`  in  8  CPU output-port value.
- `cpu_out_we`  in  1  one-cycle strobe: capture `OUT`.
- `ext_out_data`  out  8  output FIFO head; 8'h00 when empty.
- `ext_out_valid`  out  1  output FIFO non-empty.
- `ext_out_ready`  in  1  consumer accepts head.
- `out_overflow`  out  1  sticky: a CPU write was dropped.

## Operation
- Each FIFO is a circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. Each also keeps a count from 0 to DEPTH. Full means count==DEPTH; empty means count==0.
- Input push: `ext_in_valid && ext_in_ready`. `ext_in_ready` = !full only; it does not depend on `cpu_in_rd`, so there is no combinational path from pop to ready. A push and pop in the same cycle are both performed and the count is unchanged.
- Input pop: `cpu_in_rd && in_avail`. A pop while empty is ignored, with no pointer or count change.
- Output push: `cpu_out_we`. If the FIFO is full at that edge, the write is dropped and `out_overflow`←1, even if the consumer pops in the same cycle. `out_overflow` clears only on reset.
- Output pop: `ext_out_valid && ext_out_ready`. A simultaneous push and pop on a non-full FIFO are both performed.
- Interrupt logic uses a registered `announced` flag. The following is evaluated at each edge using pre-edge state:
  - If `IRQ_EN && in_avail && !announced && !pop`: `interrupt`←1 and `announced`←1.
  - Otherwise `interrupt`←0.
  - Any accepted input pop sets `announced`←0, so the next head byte (if any) is announced later.
- Reset values: FIFOs empty, pointers 0, `ext_in_ready`=1, `in_avail`=0, `input_port`=0, `interrupt`=0, `announced`=0, `ext_out_valid`=0, `ext_out_data`=0, `out_overflow`=0.

## Timing
- Input path: push at edge k puts the byte on `input_port` with `in_avail`=1 from edge k onward, provided the FIFO was empty.
- Interrupt timing: with an empty FIFO, a push at edge k drives `interrupt` high from edge k+1 to edge k+2, exactly one cycle. No re-pulse occurs while the same head remains.
- Pop at edge k: the next head appears after edge k. Its interrupt pulse follows after edge k+1.
- A pop coinciding with the announce edge suppresses that pulse. The surviving head is announced at the following edge.
- Output path: `cpu_out_we` at edge k gives `ext_out_valid`=1 and `ext_out_data`=`OUT` after edge k, provided the FIFO was empty. The consumer handshake completes at the first edge with `ext_out_ready`=1.
- Asynchronous reset asserted mid-transfer: all outputs go to their reset values immediately, and queued data is discarded. Release is synchronous to `clk`; the first push is accepted at the first edge after release.
- Throughput: one push and one pop per cycle per FIFO.

## Test plan
- Reset, then push 8'hA5 → `input_port`=8'hA5 and `in_avail`=1 next cycle; `interrupt` high exactly one cycle, one cycle later; no further pulse.
- Push 8'h11, 8'h22, 8'h33, 8'h44 with no pops (DEPTH=4) → `ext_in_ready`=0 after the fourth. A fifth byte is held, not lost. Pop → 8'h22 on `input_port`, then a fresh interrupt pulse.
- Pop while empty, repeated across a pointer wrap (push and pop 10 bytes 8'h01..8'h0A) → bytes read back in order, and the count never underflows.
- Five `cpu_out_we` with `OUT`=8'h50..8'h54 and `ext_out_ready`=0 → first four queued, `out_overflow`=1. Draining yields 8'h50..8'h53.
- Same-cycle push+pop on both FIFOs at count 2 → count stays 2 and ordering is preserved.
- Drive `reset` low mid-stream with 3 bytes queued → all outputs immediately at reset values, and `interrupt` stays 0 after release.
